// File: rtl/hps_spi_pkg.sv
// Shared types and helpers for the HPS SPI slave bridge.
package hps_spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;

  // Shift one bit into a word of 'width' bits; LSB-first inserts at the top of the word.
  function automatic logic [31:0] word_shift(input logic [31:0] word, input logic b,
                                             input logic msb_first, input int unsigned width);
    logic [31:0] r;
    if (msb_first) begin
      r = {word[30:0], b};
    end else begin
      r = word >> 1;
      r[width-1] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/hps_spi_sync.sv
// Multi-stage synchroniser with configurable reset level and edge detect on the synced value.
module hps_spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/hps_spi_bridge.sv
// SPI slave bridging the HPS SPI master to the core command decoder, oversampled in sys_clk.
module hps_spi_bridge
  import hps_spi_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int SAMPLE_EDGE = 1,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = 8
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [IDX_W-1:0]  rx_index,
  input  logic [WORD_W-1:0] tx_data,
  output logic              tx_req,
  output logic              frame_active,
  output logic              frame_end,
  output logic              err_short
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic MSBF = (MSB_FIRST != 0);

  state_t r_state, w_state_nxt;

  logic w_clk_q, w_clk_rise, w_clk_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_mosi_q, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  logic [SYNC_STAGES-1:0] r_warm;
  logic                   r_armed;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [IDX_W-1:0]       r_index;
  logic [WORD_W-1:0]      r_rx_shift;
  logic [WORD_W-1:0]      r_tx_shift;
  logic                   r_sampled;
  logic                   r_load_pending;
  logic [WORD_W-1:0]      r_rx_data;
  logic                   r_rx_valid;
  logic [IDX_W-1:0]       r_rx_index;
  logic                   r_frame_end;
  logic                   r_err_short;

  logic              w_samp_edge, w_shift_edge;
  logic              w_start, w_stop, w_samp, w_shift, w_load, w_last;
  logic [WORD_W-1:0] w_rx_next, w_tx_next;

  hps_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
    .i_clk(sys_clk), .i_rst_n(reset_n), .i_d(spi_clk),
    .o_q(w_clk_q), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
  );

  hps_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .i_clk(sys_clk), .i_rst_n(reset_n), .i_d(spi_cs),
    .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  hps_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .i_clk(sys_clk), .i_rst_n(reset_n), .i_d(spi_mosi),
    .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused = &{w_clk_q, w_mosi_rise, w_mosi_fall};

  assign w_samp_edge  = (SAMPLE_EDGE == EDGE_FALL) ? w_clk_fall : w_clk_rise;
  assign w_shift_edge = (SAMPLE_EDGE == EDGE_FALL) ? w_clk_rise : w_clk_fall;

  assign w_rx_next = WORD_W'(word_shift(32'(r_rx_shift), w_mosi_q, MSBF, WORD_W));
  assign w_tx_next = WORD_W'(word_shift(32'(r_tx_shift), 1'b0, MSBF, WORD_W));

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall && r_armed) begin
          w_start     = 1'b1;
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_cs_rise) begin
          w_stop      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift edges only count once a bit has been sampled, and never on the closing cycle.
  assign w_samp  = (r_state == ACTIVE) && w_samp_edge;
  assign w_shift = (r_state == ACTIVE) && w_shift_edge && r_sampled && !w_cs_rise;
  assign w_load  = w_shift && r_load_pending;
  assign w_last  = w_samp && (r_bit_cnt == CNT_W'(WORD_W - 1));

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_warm         <= '0;
      r_armed        <= 1'b0;
      r_bit_cnt      <= '0;
      r_index        <= '0;
      r_rx_shift     <= '0;
      r_tx_shift     <= '0;
      r_sampled      <= 1'b0;
      r_load_pending <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rx_index     <= '0;
      r_frame_end    <= 1'b0;
      r_err_short    <= 1'b0;
    end else begin
      // The cs synchroniser only carries real pin samples once r_warm has filled.
      r_warm <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      if (r_warm[SYNC_STAGES-1] && w_cs_q) begin
        r_armed <= 1'b1;
      end
      r_rx_valid  <= 1'b0;
      r_frame_end <= w_stop;

      if (w_start) begin
        r_tx_shift     <= tx_data;
        r_rx_shift     <= '0;
        r_bit_cnt      <= '0;
        r_index        <= '0;
        r_err_short    <= 1'b0;
        r_sampled      <= 1'b0;
        r_load_pending <= 1'b0;
      end

      if (w_samp) begin
        r_rx_shift <= w_rx_next;
        r_sampled  <= 1'b1;
        if (w_last) begin
          r_rx_data      <= w_rx_next;
          r_rx_valid     <= 1'b1;
          r_rx_index     <= r_index;
          r_bit_cnt      <= '0;
          r_load_pending <= 1'b1;
          if (r_index != {IDX_W{1'b1}}) begin
            r_index <= r_index + 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end

      if (w_shift) begin
        r_sampled <= 1'b0;
        if (r_load_pending) begin
          r_tx_shift     <= tx_data;
          r_load_pending <= 1'b0;
        end else begin
          r_tx_shift <= w_tx_next;
        end
      end

      // A sample in the closing cycle is counted before deciding the word was short.
      if (w_stop) begin
        r_load_pending <= 1'b0;
        r_sampled      <= 1'b0;
        if (!w_last && (w_samp || (r_bit_cnt != '0))) begin
          r_err_short <= 1'b1;
        end
      end
    end
  end

  assign tx_req       = w_start || w_load;
  assign frame_active = (r_state == ACTIVE);
  assign spi_miso     = (r_state == ACTIVE) && (MSBF ? r_tx_shift[WORD_W-1] : r_tx_shift[0]);
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_index     = r_rx_index;
  assign frame_end    = r_frame_end;
  assign err_short    = r_err_short;

endmodule

// File: tb/tb_hps_spi_bridge.sv
// Scoreboard bench for hps_spi_bridge across three parameter sets sharing spi_clk/spi_mosi.
module tb_hps_spi_bridge;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  idx;
  } rx_exp_t;

  logic       sys_clk = 1'b0;
  logic       reset_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic [2:0] cs;
  logic [15:0] tx0;
  logic [7:0]  tx1, tx2;

  logic [15:0] rx_data0;
  logic [7:0]  rx_data1, rx_data2;
  logic [7:0]  rx_index0, rx_index1;
  logic [1:0]  rx_index2;
  logic [2:0]  rxv, fe, fa, err, miso, txr;
  logic [31:0] rxd [3];
  logic [7:0]  rxi [3];

  rx_exp_t     exp_q [3][$];
  logic [31:0] txq [3][$];
  logic [31:0] fw [8];
  logic [31:0] cap_miso [8];
  logic        cap_active, cap_err;
  logic [2:0]  pend = 3'b000;

  int total = 0;
  int bad = 0;
  int rx_cnt [3] = '{0, 0, 0};
  int fe_cnt [3] = '{0, 0, 0};
  int txr_cnt [3] = '{0, 0, 0};

  always #5 sys_clk = ~sys_clk;

  hps_spi_bridge #(.WORD_W(16), .SAMPLE_EDGE(1), .MSB_FIRST(1), .SYNC_STAGES(2), .IDX_W(8)) u_dut0 (
    .sys_clk(sys_clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_cs(cs[0]), .spi_mosi(spi_mosi),
    .spi_miso(miso[0]), .rx_data(rx_data0), .rx_valid(rxv[0]), .rx_index(rx_index0),
    .tx_data(tx0), .tx_req(txr[0]), .frame_active(fa[0]), .frame_end(fe[0]), .err_short(err[0])
  );

  hps_spi_bridge #(.WORD_W(8), .SAMPLE_EDGE(0), .MSB_FIRST(0), .SYNC_STAGES(2), .IDX_W(8)) u_dut1 (
    .sys_clk(sys_clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_cs(cs[1]), .spi_mosi(spi_mosi),
    .spi_miso(miso[1]), .rx_data(rx_data1), .rx_valid(rxv[1]), .rx_index(rx_index1),
    .tx_data(tx1), .tx_req(txr[1]), .frame_active(fa[1]), .frame_end(fe[1]), .err_short(err[1])
  );

  hps_spi_bridge #(.WORD_W(8), .SAMPLE_EDGE(1), .MSB_FIRST(1), .SYNC_STAGES(2), .IDX_W(2)) u_dut2 (
    .sys_clk(sys_clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_cs(cs[2]), .spi_mosi(spi_mosi),
    .spi_miso(miso[2]), .rx_data(rx_data2), .rx_valid(rxv[2]), .rx_index(rx_index2),
    .tx_data(tx2), .tx_req(txr[2]), .frame_active(fa[2]), .frame_end(fe[2]), .err_short(err[2])
  );

  assign rxd[0] = 32'(rx_data0);
  assign rxd[1] = 32'(rx_data1);
  assign rxd[2] = 32'(rx_data2);
  assign rxi[0] = rx_index0;
  assign rxi[1] = rx_index1;
  assign rxi[2] = 8'(rx_index2);

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic set_tx(input int d, input logic [31:0] v);
    case (d)
      0:       tx0 = v[15:0];
      1:       tx1 = v[7:0];
      default: tx2 = v[7:0];
    endcase
  endtask

  // Output scoreboard and strobe counters, sampled mid-cycle.
  always @(negedge sys_clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rxv[d] === 1'b1) begin
        rx_cnt[d]++;
        total++;
        if (exp_q[d].size() == 0) begin
          bad++;
          $display("FAIL rx_unexpected dut%0d: got data=%h idx=%0d, expected no word", d, rxd[d], rxi[d]);
        end else begin
          rx_exp_t e;
          e = exp_q[d].pop_front();
          if (rxd[d] !== e.data || rxi[d] !== e.idx) begin
            bad++;
            $display("FAIL rx_word dut%0d: got data=%h idx=%0d, expected data=%h idx=%0d",
                     d, rxd[d], rxi[d], e.data, e.idx);
          end
        end
      end
      if (fe[d] === 1'b1) fe_cnt[d]++;
      if (txr[d] === 1'b1) begin
        txr_cnt[d]++;
        pend[d] = 1'b1;
      end
    end
  end

  // Host side of the tx handshake: present the next word after each load edge.
  always @(posedge sys_clk) begin
    #1;
    for (int d = 0; d < 3; d++) begin
      if (pend[d]) begin
        pend[d] = 1'b0;
        if (txq[d].size() > 0) set_tx(d, txq[d].pop_front());
        else set_tx(d, 32'h0);
      end
    end
  end

  task automatic run_frame(input int d, input int nfull, input int tail, input int h);
    int wd, maxidx, nb, bp;
    logic msbf, idle;
    logic [31:0] mask, acc;
    rx_exp_t e;
    wd     = (d == 0) ? 16 : 8;
    msbf   = (d != 1);
    idle   = (d != 1);
    mask   = (d == 0) ? 32'hFFFF : 32'hFF;
    maxidx = (d == 2) ? 3 : 255;
    spi_clk  = idle;
    spi_mosi = 1'b0;
    step(h);
    cs[d] = 1'b0;
    step(h + 6);
    cap_active = fa[d];
    cap_err    = err[d];
    for (int w = 0; w <= nfull; w++) begin
      nb = (w < nfull) ? wd : tail;
      if (w < nfull) begin
        e.data = fw[w] & mask;
        e.idx  = 8'((w > maxidx) ? maxidx : w);
        exp_q[d].push_back(e);
      end
      acc = '0;
      for (int i = 0; i < nb; i++) begin
        bp = msbf ? (wd - 1 - i) : i;
        spi_mosi = fw[w][bp];
        step(h);
        acc[bp] = miso[d];
        spi_clk = ~idle;
        step(h);
        spi_clk = idle;
      end
      if (w < 8) cap_miso[w] = acc;
    end
    step(h);
    cs[d] = 1'b1;
    step(h + 12);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({rxv[d], fe[d], fa[d], err[d], miso[d], txr[d]} !== 6'b0) begin
        bad++;
        $display("FAIL reset_ctrl dut%0d: got %b, expected 000000", d,
                 {rxv[d], fe[d], fa[d], err[d], miso[d], txr[d]});
      end
      total++;
      if (rxd[d] !== 32'h0 || rxi[d] !== 8'h0) begin
        bad++;
        $display("FAIL reset_data dut%0d: got data=%h idx=%0d, expected 0/0", d, rxd[d], rxi[d]);
      end
    end
  endtask

  task automatic test_single_word();
    int b_rx, b_fe, b_tx;
    b_rx = rx_cnt[0]; b_fe = fe_cnt[0]; b_tx = txr_cnt[0];
    txq[0].delete();
    txq[0].push_back(32'h0);
    set_tx(0, 32'h1234);
    fw[0] = 32'hA55A;
    run_frame(0, 1, 0, 8);
    total++;
    if (cap_miso[0] !== 32'h1234) begin bad++; $display("FAIL single_miso: got %h, expected 1234", cap_miso[0]); end
    total++;
    if (rx_cnt[0] - b_rx != 1) begin bad++; $display("FAIL single_rx_count: got %0d, expected 1", rx_cnt[0] - b_rx); end
    total++;
    if (txr_cnt[0] - b_tx != 2) begin bad++; $display("FAIL single_tx_req: got %0d, expected 2", txr_cnt[0] - b_tx); end
    total++;
    if (fe_cnt[0] - b_fe != 1) begin bad++; $display("FAIL single_frame_end: got %0d, expected 1", fe_cnt[0] - b_fe); end
    total++;
    if (cap_active !== 1'b1 || fa[0] !== 1'b0) begin
      bad++; $display("FAIL single_active: got during=%b after=%b, expected 1/0", cap_active, fa[0]);
    end
  endtask

  task automatic test_three_words();
    int b_rx;
    b_rx = rx_cnt[0];
    txq[0].delete();
    txq[0].push_back(32'hB1);
    txq[0].push_back(32'hB2);
    txq[0].push_back(32'h0);
    set_tx(0, 32'hB0);
    fw[0] = 32'h0001; fw[1] = 32'h0002; fw[2] = 32'h0003;
    run_frame(0, 3, 0, 8);
    for (int w = 0; w < 3; w++) begin
      total++;
      if (cap_miso[w] !== 32'hB0 + 32'(w)) begin
        bad++; $display("FAIL three_miso%0d: got %h, expected %h", w, cap_miso[w], 32'hB0 + 32'(w));
      end
    end
    total++;
    if (rx_cnt[0] - b_rx != 3 || err[0] !== 1'b0) begin
      bad++; $display("FAIL three_rx: got count=%0d err=%b, expected 3/0", rx_cnt[0] - b_rx, err[0]);
    end
  endtask

  task automatic test_short_word();
    int b_rx, b_fe;
    b_rx = rx_cnt[0]; b_fe = fe_cnt[0];
    txq[0].delete();
    set_tx(0, 32'h0);
    fw[0] = 32'h1111; fw[1] = 32'h2222;
    run_frame(0, 1, 7, 8);
    total++;
    if (err[0] !== 1'b1) begin bad++; $display("FAIL short_err: got %b, expected 1", err[0]); end
    total++;
    if (rx_cnt[0] - b_rx != 1 || fe_cnt[0] - b_fe != 1) begin
      bad++; $display("FAIL short_counts: got rx=%0d fe=%0d, expected 1/1", rx_cnt[0] - b_rx, fe_cnt[0] - b_fe);
    end
    fw[0] = 32'h4321;
    run_frame(0, 1, 0, 8);
    total++;
    if (cap_err !== 1'b0 || err[0] !== 1'b0) begin
      bad++; $display("FAIL short_clear: got at_start=%b after=%b, expected 0/0", cap_err, err[0]);
    end
  endtask

  task automatic test_cs_low_reset();
    int b_rx, b_fe;
    reset_n = 1'b0;
    spi_clk = 1'b1;
    cs[0]   = 1'b0;
    step(5);
    reset_n = 1'b1;
    step(10);
    b_rx = rx_cnt[0]; b_fe = fe_cnt[0];
    for (int i = 0; i < 16; i++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      step(8);
      spi_clk = 1'b0;
      step(8);
      spi_clk = 1'b1;
    end
    step(10);
    total++;
    if (rx_cnt[0] - b_rx != 0 || fa[0] !== 1'b0 || fe_cnt[0] - b_fe != 0) begin
      bad++; $display("FAIL cs_low_ignored: got rx=%0d active=%b fe=%0d, expected 0/0/0",
                      rx_cnt[0] - b_rx, fa[0], fe_cnt[0] - b_fe);
    end
    cs[0] = 1'b1;
    step(10);
    b_rx = rx_cnt[0];
    txq[0].delete();
    set_tx(0, 32'h5A5A);
    fw[0] = 32'hC3A5;
    run_frame(0, 1, 0, 8);
    total++;
    if (rx_cnt[0] - b_rx != 1 || cap_miso[0] !== 32'h5A5A) begin
      bad++; $display("FAIL cs_rearm: got rx=%0d miso=%h, expected 1/5a5a", rx_cnt[0] - b_rx, cap_miso[0]);
    end
  endtask

  task automatic test_lsb8();
    int b_rx, b_fe;
    b_rx = rx_cnt[1]; b_fe = fe_cnt[1];
    txq[1].delete();
    set_tx(1, 32'h3C);
    fw[0] = 32'h81;
    run_frame(1, 1, 0, 8);
    total++;
    if (cap_miso[0] !== 32'h3C) begin bad++; $display("FAIL lsb_miso: got %h, expected 3c", cap_miso[0]); end
    total++;
    if (rx_cnt[1] - b_rx != 1 || fe_cnt[1] - b_fe != 1) begin
      bad++; $display("FAIL lsb_counts: got rx=%0d fe=%0d, expected 1/1", rx_cnt[1] - b_rx, fe_cnt[1] - b_fe);
    end
  endtask

  task automatic test_idx_sat();
    int b_rx;
    b_rx = rx_cnt[2];
    txq[2].delete();
    set_tx(2, 32'h0);
    fw[0] = 32'h11; fw[1] = 32'h22; fw[2] = 32'h33; fw[3] = 32'h44; fw[4] = 32'h55;
    run_frame(2, 5, 0, 2);
    total++;
    if (rx_cnt[2] - b_rx != 5 || err[2] !== 1'b0) begin
      bad++; $display("FAIL idx_sat_count: got rx=%0d err=%b, expected 5/0", rx_cnt[2] - b_rx, err[2]);
    end
  endtask

  task automatic test_drain();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (exp_q[d].size() != 0) begin
        bad++; $display("FAIL rx_missing dut%0d: got %0d words outstanding, expected 0", d, exp_q[d].size());
      end
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    cs       = 3'b111;
    spi_clk  = 1'b1;
    spi_mosi = 1'b0;
    tx0 = '0; tx1 = '0; tx2 = '0;
    #1 reset_n = 1'b0;
    step(5);
    test_reset();
    reset_n = 1'b1;
    step(10);
    test_single_word();
    test_three_words();
    test_short_word();
    test_cs_low_reset();
    test_lsb8();
    test_idx_sat();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hps_spi_bridge.md
Name: hps_spi_bridge

Overview:
Parametrised SPI slave between the HPS SPI master and the core, fully in the sys_clk domain. spi_clk, spi_cs and spi_mosi are oversampled through synchronisers.
Adds over the current HPS interface: configurable word width, bit order and sample edge; a per-frame word index; a TX load handshake; frame-end and short-word reporting.
Feeds the core's command decoder with rx words and takes reply words from it.

Parameters:
WORD_W, 16, bits per SPI word (4..32)
SAMPLE_EDGE, 1, spi_clk edge on which MOSI is sampled (0 rising, 1 falling); MISO shifts on the opposite edge
MSB_FIRST, 1, 1 shifts MSB first, 0 shifts LSB first
SYNC_STAGES, 2, synchroniser depth on spi_clk/spi_cs/spi_mosi (>=2)
IDX_W, 8, width of the word-in-frame index

Ports:
sys_clk  in  1  system clock; must be >=4x spi_clk, each spi_clk phase >=2 sys_clk
reset_n  in  1  asynchronous, active-low reset
spi_clk  in  1  SPI clock from HPS
spi_cs  in  1  chip select, high = deselected
spi_mosi  in  1  master data
spi_miso  out  1  slave data
rx_data  out  WORD_W  last complete received word
rx_valid  out  1  1-cycle strobe, rx_data/rx_index valid
rx_index  out  IDX_W  position of rx_data in current frame (0 = first)
tx_data  in  WORD_W  next word to send; sampled when tx_req pulses
tx_req  out  1  1-cycle strobe, tx_data loaded this cycle; present the following word before the next load
frame_active  out  1  high while a frame is open
frame_end  out  1  1-cycle strobe on frame close
err_short  out  1  sticky; frame closed with a partial word

Behaviour:
- Reset values: all outputs 0. The spi_cs synchroniser resets to 1 and the spi_clk synchroniser to 0. bit_cnt, index and shifters reset to 0.
- After reset, a frame may start only once synced cs has been seen high for >=1 cycle (armed flag). CS already low at reset release is ignored until it goes high.
- Edge detect: compare the last two synced spi_clk samples. sample_edge and shift_edge are selected by SAMPLE_EDGE.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on synced cs falling while armed, in the same cycle:
  - tx_shift <= tx_data; tx_req=1
  - bit_cnt=0, index=0, err_short=0
  - frame_active=1 from the next cycle
- ACTIVE, sample_edge:
  - shift synced mosi into rx_shift (MSB_FIRST selects direction); bit_cnt++; set sampled flag
  - if bit_cnt==WORD_W-1: in the next cycle rx_data <= completed word, rx_valid=1, rx_index=index
  - then index++, saturating at 2^IDX_W-1; bit_cnt=0; set load_pending
- ACTIVE, shift_edge, acted on only if sampled flag is set:
  - if load_pending: tx_shift <= tx_data, tx_req=1, clear load_pending
  - otherwise shift tx_shift by one
  - clear sampled flag
  - shift_edge before the first sample_edge of a frame is ignored
- spi_miso: tx_shift MSB (LSB if MSB_FIRST=0) while ACTIVE; 0 in IDLE.
- ACTIVE -> IDLE on synced cs rising:
  - frame_end=1 for one cycle; frame_active=0
  - if bit_cnt!=0: partial word discarded, no rx_valid, err_short=1
  - load_pending cleared; no tx_req
- Sample_edge and cs rising detected in the same cycle: the sample is taken first. A completed word produces rx_valid in the same cycle as frame_end.
- Latency: pin edge to internal detect = SYNC_STAGES+1 sys_clk; rx_valid 1 cycle after that.
- Async reset mid-frame: return to IDLE immediately. No strobes; the armed rule applies.

Decomposition:
- Package hps_spi_pkg: state enum (IDLE, ACTIVE); edge-select constants EDGE_RISE=0, EDGE_FALL=1; a function word_shift(word, bit, msb_first).
- One sub-module hps_spi_sync: SYNC_STAGES-deep synchroniser with reset value parameter, plus rise/fall detect. Instantiated for spi_clk and spi_cs; spi_mosi uses the plain synchroniser output.

Test Plan:
- WORD_W=16, SAMPLE_EDGE=1, MSB_FIRST=1; one frame sending 0xA55A with tx_data=0x1234 -> rx_data=0xA55A, rx_valid once, rx_index=0; MISO bits read 0x1234; tx_req at frame start and at the word-1 load; frame_end once.
- Three-word frame 0x0001,0x0002,0x0003; host updates tx_data on each tx_req to 0xB0,0xB1,0xB2 -> rx_index 0,1,2; MISO carries 0xB0,0xB1,0xB2 in order; err_short=0.
- CS rises after 7 bits of the second word -> no second rx_valid, err_short=1, frame_end=1. The next frame start clears err_short.
- Hold CS low through reset_n release, then clock 16 bits -> no rx_valid. CS high then low -> normal frame decoding.
- WORD_W=8, SAMPLE_EDGE=0, MSB_FIRST=0; send 0x81 LSB-first -> rx_data=0x81. MISO for tx_data=0x3C is bit order 0,0,1,1,1,1,0,0.
- IDX_W=2; five-word frame -> rx_index 0,1,2,3,3 (saturation); spi_clk at sys_clk/4 throughout.
